// File: rtl/ibex_ahb_pkg.sv
// Shared constants and types for the Ibex AHB-Lite master bridge.
package ibex_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Privileged access; bit0 distinguishes opcode fetch from data access.
  localparam logic [3:0] HPROT_OPCODE = 4'b0010;
  localparam logic [3:0] HPROT_DATA   = 4'b0011;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

endpackage

// File: rtl/ibex_ahb_be_decode.sv
// Maps an Ibex byte-enable pattern onto an AHB size and low address bits.
// Patterns AHB cannot express in one transfer are flagged as illegal.
module ibex_ahb_be_decode
  import ibex_ahb_pkg::*;
(
  input  logic [3:0] be,
  output logic [2:0] hsize,
  output logic [1:0] offset,
  output logic       illegal
);

  // Decode byte enables into size, offset and legality.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    hsize   = HSIZE_WORD;
    offset  = 2'b00;
    illegal = 1'b0;
    case (be)
      4'b0001: begin hsize = HSIZE_BYTE; offset = 2'd0; end
      4'b0010: begin hsize = HSIZE_BYTE; offset = 2'd1; end
      4'b0100: begin hsize = HSIZE_BYTE; offset = 2'd2; end
      4'b1000: begin hsize = HSIZE_BYTE; offset = 2'd3; end
      4'b0011: begin hsize = HSIZE_HALF; offset = 2'd0; end
      4'b1100: begin hsize = HSIZE_HALF; offset = 2'd2; end
      4'b1111: begin hsize = HSIZE_WORD; offset = 2'd0; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ibex_ahb_bridge.sv
// Pipelined AHB-Lite master bridge for the Ibex instruction and data ports.
// Address and data phases overlap; at most one data phase is outstanding.
// Optional SysTick generator enabled by defining IBEX_AHB_SYSTICK_EN.
module ibex_ahb_bridge
  import ibex_ahb_pkg::*;
#(
  parameter int ARB_RR    = 0,
  parameter int SYSTICK_W = 24
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 instr_req_i,
  input  logic [31:0]          instr_addr_i,
  output logic                 instr_gnt_o,
  output logic                 instr_rvalid_o,
  output logic [31:0]          instr_rdata_o,
  output logic                 instr_err_o,
  input  logic                 data_req_i,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [31:0]          data_wdata_i,
  output logic                 data_gnt_o,
  output logic                 data_rvalid_o,
  output logic [31:0]          data_rdata_o,
  output logic                 data_err_o,
  output logic [31:0]          HADDR,
  output logic [1:0]           HTRANS,
  output logic [2:0]           HSIZE,
  output logic                 HWRITE,
  output logic [3:0]           HPROT,
  output logic [31:0]          HWDATA,
  input  logic [31:0]          HRDATA,
  input  logic                 HREADY,
  input  logic                 HRESP,
  input  logic [SYSTICK_W-1:0] SYSTICKCLKDIV,
  output logic                 irq_timer_o
);

  logic [2:0]  be_hsize;
  logic [1:0]  be_offset;
  logic        be_illegal;

  owner_e      rr_prio, hold_owner, dp_owner, winner;
  logic        hold_valid, dp_valid, dp_we, lerr_pending;
  logic [31:0] dp_wdata;
  logic        winner_req, err_stall, local_err, nonseq, accept;
  logic        dp_done, dp_instr_done, dp_data_done;
  logic        unused_addr;

  ibex_ahb_be_decode u_be_decode (
    .be      (data_be_i),
    .hsize   (be_hsize),
    .offset  (be_offset),
    .illegal (be_illegal)
  );

  // Pick the port that owns the address phase this cycle.
  always_comb begin
    winner = OWN_DATA;
    if (hold_valid) begin
      winner = hold_owner;
    end else if (ARB_RR != 0) begin
      if (rr_prio == OWN_DATA) winner = data_req_i  ? OWN_DATA  : OWN_INSTR;
      else                     winner = instr_req_i ? OWN_INSTR : OWN_DATA;
    end else begin
      winner = data_req_i ? OWN_DATA : OWN_INSTR;
    end
  end

  assign winner_req = (winner == OWN_DATA) ? data_req_i : instr_req_i;
  // First cycle of a two-cycle error response: the address phase must go IDLE.
  assign err_stall  = dp_valid & HRESP & ~HREADY;
  assign local_err  = (winner == OWN_DATA) & be_illegal;
  assign nonseq     = winner_req & ~err_stall & ~lerr_pending & ~local_err;
  assign accept     = winner_req & HREADY & ~lerr_pending;

  assign instr_gnt_o = accept & (winner == OWN_INSTR);
  assign data_gnt_o  = accept & (winner == OWN_DATA);

  // Drive the address phase; control is zero whenever no transfer is issued.
  always_comb begin
    HTRANS = HTRANS_IDLE;
    HADDR  = '0;
    HSIZE  = '0;
    HWRITE = 1'b0;
    HPROT  = '0;
    if (nonseq) begin
      HTRANS = HTRANS_NONSEQ;
      if (winner == OWN_DATA) begin
        HADDR  = {data_addr_i[31:2], be_offset};
        HSIZE  = be_hsize;
        HWRITE = data_we_i;
        HPROT  = HPROT_DATA;
      end else begin
        HADDR  = instr_addr_i;
        HSIZE  = HSIZE_WORD;
        HPROT  = HPROT_OPCODE;
      end
    end
  end

  // Arbitration hold, round-robin pointer, data-phase and local-error state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rr_prio      <= OWN_DATA;
      hold_valid   <= 1'b0;
      hold_owner   <= OWN_INSTR;
      dp_valid     <= 1'b0;
      dp_owner     <= OWN_INSTR;
      dp_we        <= 1'b0;
      dp_wdata     <= '0;
      lerr_pending <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      if (nonseq && !HREADY) begin
        hold_valid <= 1'b1;
        hold_owner <= winner;
      end else if (accept) begin
        hold_valid <= 1'b0;
      end

      if (accept) rr_prio <= (winner == OWN_DATA) ? OWN_INSTR : OWN_DATA;

      if (accept) begin
        dp_valid <= ~local_err;
        dp_owner <= winner;
        dp_we    <= (winner == OWN_DATA) & data_we_i & ~local_err;
        if (winner == OWN_DATA) dp_wdata <= data_wdata_i;
      end else if (HREADY) begin
        dp_valid <= 1'b0;
      end

      lerr_pending <= accept & local_err;
    end
  end

  assign HWDATA = dp_we ? dp_wdata : '0;

  assign dp_done       = dp_valid & HREADY;
  assign dp_instr_done = dp_done & (dp_owner == OWN_INSTR);
  assign dp_data_done  = dp_done & (dp_owner == OWN_DATA);

  assign instr_rvalid_o = dp_instr_done;
  assign instr_rdata_o  = dp_instr_done ? HRDATA : '0;
  assign instr_err_o    = dp_instr_done & HRESP;

  assign data_rvalid_o  = dp_data_done | lerr_pending;
  assign data_rdata_o   = dp_data_done ? HRDATA : '0;
  assign data_err_o     = (dp_data_done & HRESP) | lerr_pending;

`ifdef IBEX_AHB_SYSTICK_EN
  logic [SYSTICK_W-1:0] tick_cnt;
  logic                 tick_match;

  assign tick_match = (tick_cnt == SYSTICKCLKDIV);

  // Free-running divider; the pulse is registered one cycle after the match.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tick_cnt    <= '0;
      irq_timer_o <= 1'b1;
    end else begin
      tick_cnt    <= tick_match ? '0 : tick_cnt + {{(SYSTICK_W-1){1'b0}}, 1'b1};
      irq_timer_o <= tick_match;
    end
  end

  assign unused_addr = ^data_addr_i[1:0];
`else
  assign irq_timer_o = 1'b0;
  assign unused_addr = ^{data_addr_i[1:0], SYSTICKCLKDIV};
`endif

endmodule

// File: tb/tb_ibex_ahb_bridge.sv
// Directed bench for ibex_ahb_bridge: a fixed-priority and a round-robin instance
// share stimulus. Define IBEX_AHB_SYSTICK_EN to exercise the SysTick generator.
module tb_ibex_ahb_bridge;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic [31:0] HRDATA;
  logic        HREADY, HRESP;
  logic [23:0] SYSTICKCLKDIV;

  // Fixed-priority instance outputs
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [3:0]  HPROT;
  logic        irq_timer_o;

  // Round-robin instance outputs
  logic        r_instr_gnt, r_instr_rvalid, r_instr_err;
  logic [31:0] r_instr_rdata;
  logic        r_data_gnt, r_data_rvalid, r_data_err;
  logic [31:0] r_data_rdata;
  logic [31:0] r_haddr, r_hwdata;
  logic [1:0]  r_htrans;
  logic [2:0]  r_hsize;
  logic        r_hwrite;
  logic [3:0]  r_hprot;
  logic        r_irq;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  ibex_ahb_bridge #(.ARB_RR(0), .SYSTICK_W(24)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .SYSTICKCLKDIV(SYSTICKCLKDIV), .irq_timer_o(irq_timer_o)
  );

  ibex_ahb_bridge #(.ARB_RR(1), .SYSTICK_W(24)) dut_rr (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(r_instr_gnt), .instr_rvalid_o(r_instr_rvalid),
    .instr_rdata_o(r_instr_rdata), .instr_err_o(r_instr_err),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(r_data_gnt), .data_rvalid_o(r_data_rvalid),
    .data_rdata_o(r_data_rdata), .data_err_o(r_data_err),
    .HADDR(r_haddr), .HTRANS(r_htrans), .HSIZE(r_hsize), .HWRITE(r_hwrite),
    .HPROT(r_hprot), .HWDATA(r_hwdata), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .SYSTICKCLKDIV(SYSTICKCLKDIV), .irq_timer_o(r_irq)
  );

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [1:0]  e_trans;
    logic [31:0] e_haddr;
    logic [2:0]  e_hsize;
    logic        e_hwrite;
    logic [3:0]  e_hprot;
    logic        e_ig;
    logic        e_dg;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req_i  = 1'b0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'b1111;
    data_wdata_i = '0;
  endtask

  initial begin
    logic found;
    logic exp_irq_rst;
    logic [3:0] rr_exp_i;

    HRESETn      = 1'b0;
    instr_addr_i = '0;
    data_addr_i  = '0;
    HRDATA       = '0;
    HREADY       = 1'b1;
    HRESP        = 1'b0;
    SYSTICKCLKDIV = 24'd4;
    idle_inputs();

`ifdef IBEX_AHB_SYSTICK_EN
    exp_irq_rst = 1'b1;
`else
    exp_irq_rst = 1'b0;
`endif

    // idle, instr, data sizes/offsets, contention, illegal patterns
    vecs[0]  = '{1'b0, 32'h0,   1'b0, 1'b0, 4'b1111, 32'h0,        2'b00, 32'h0,        3'b000, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 4'b1111, 32'h0,        2'b10, 32'h100,      3'b010, 1'b0, 4'b0010, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,   1'b1, 1'b0, 4'b1111, 32'h3000_0004, 2'b10, 32'h3000_0004, 3'b010, 1'b0, 4'b0011, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 32'h0,   1'b1, 1'b0, 4'b0001, 32'h3000_0007, 2'b10, 32'h3000_0004, 3'b000, 1'b0, 4'b0011, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 32'h0,   1'b1, 1'b0, 4'b0010, 32'h3000_0010, 2'b10, 32'h3000_0011, 3'b000, 1'b0, 4'b0011, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 32'h0,   1'b1, 1'b1, 4'b1000, 32'h4000_0000, 2'b10, 32'h4000_0003, 3'b000, 1'b1, 4'b0011, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 32'h0,   1'b1, 1'b1, 4'b0011, 32'h4000_0000, 2'b10, 32'h4000_0000, 3'b001, 1'b1, 4'b0011, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 32'h0,   1'b1, 1'b1, 4'b1100, 32'h4000_0000, 2'b10, 32'h4000_0002, 3'b001, 1'b1, 4'b0011, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 32'h104, 1'b1, 1'b0, 4'b1111, 32'h5000_0000, 2'b10, 32'h5000_0000, 3'b010, 1'b0, 4'b0011, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 32'h0,   1'b1, 1'b0, 4'b0000, 32'h5000_0000, 2'b00, 32'h0,        3'b000, 1'b0, 4'b0000, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 32'h108, 1'b0, 1'b0, 4'b1111, 32'h0,        2'b00, 32'h0,        3'b000, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'h108, 1'b0, 1'b0, 4'b1111, 32'h0,        2'b10, 32'h108,      3'b010, 1'b0, 4'b0010, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 32'h10C, 1'b1, 1'b0, 4'b1010, 32'h6000_0000, 2'b00, 32'h0,        3'b000, 1'b0, 4'b0000, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 32'h0,   1'b0, 1'b0, 4'b1111, 32'h0,        2'b00, 32'h0,        3'b000, 1'b0, 4'b0000, 1'b0, 1'b0};

    // Reset state
    #12;
    check("rst_htrans", {30'b0, HTRANS}, 32'h0);
    check("rst_gnts", {28'b0, instr_gnt_o, data_gnt_o, r_instr_gnt, r_data_gnt}, 32'h0);
    check("rst_rvalids", {30'b0, instr_rvalid_o, data_rvalid_o}, 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_irq", {31'b0, irq_timer_o}, {31'b0, exp_irq_rst});
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Table-driven address-phase vectors, HREADY held high
    for (int i = 0; i < 14; i++) begin
      tick();
      instr_req_i  = vecs[i].ireq;
      instr_addr_i = vecs[i].iaddr;
      data_req_i   = vecs[i].dreq;
      data_we_i    = vecs[i].dwe;
      data_be_i    = vecs[i].dbe;
      data_addr_i  = vecs[i].daddr;
      @(negedge HCLK);
      check($sformatf("v%0d_htrans", i), {30'b0, HTRANS}, {30'b0, vecs[i].e_trans});
      check($sformatf("v%0d_haddr", i), HADDR, vecs[i].e_haddr);
      check($sformatf("v%0d_hsize", i), {29'b0, HSIZE}, {29'b0, vecs[i].e_hsize});
      check($sformatf("v%0d_hwrite", i), {31'b0, HWRITE}, {31'b0, vecs[i].e_hwrite});
      check($sformatf("v%0d_hprot", i), {28'b0, HPROT}, {28'b0, vecs[i].e_hprot});
      check($sformatf("v%0d_gnt", i), {30'b0, instr_gnt_o, data_gnt_o},
            {30'b0, vecs[i].e_ig, vecs[i].e_dg});
    end

    // Instruction fetch: gnt at N, rvalid with HRDATA at N+1
    tick(); idle_inputs();
    instr_req_i = 1'b1; instr_addr_i = 32'h100;
    @(negedge HCLK);
    check("if_gnt", {31'b0, instr_gnt_o}, 32'h1);
    check("if_haddr", HADDR, 32'h100);
    tick(); instr_req_i = 1'b0; HRDATA = 32'hDEAD_BEEF;
    @(negedge HCLK);
    check("if_rvalid", {31'b0, instr_rvalid_o}, 32'h1);
    check("if_rdata", instr_rdata_o, 32'hDEAD_BEEF);
    check("if_no_drvalid", {31'b0, data_rvalid_o}, 32'h0);

    // Byte write: address/size in address phase, HWDATA in data phase
    tick();
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0100;
    data_addr_i = 32'h2000_0008; data_wdata_i = 32'h00AB_0000;
    @(negedge HCLK);
    check("bw_haddr", HADDR, 32'h2000_000A);
    check("bw_hsize", {29'b0, HSIZE}, 32'h0);
    check("bw_hwrite", {31'b0, HWRITE}, 32'h1);
    check("bw_gnt", {31'b0, data_gnt_o}, 32'h1);
    tick(); idle_inputs();
    @(negedge HCLK);
    check("bw_hwdata", HWDATA, 32'h00AB_0000);
    check("bw_rvalid", {31'b0, data_rvalid_o}, 32'h1);

    // Three wait states with an instruction request pending
    tick();
    data_req_i = 1'b1; data_be_i = 4'b1111; data_addr_i = 32'h3000_0000;
    @(negedge HCLK);
    check("ws_dgnt", {31'b0, data_gnt_o}, 32'h1);
    tick(); idle_inputs();
    instr_req_i = 1'b1; instr_addr_i = 32'h200; HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      check($sformatf("ws%0d_no_gnt", i), {31'b0, instr_gnt_o}, 32'h0);
      check($sformatf("ws%0d_no_rvalid", i), {31'b0, data_rvalid_o}, 32'h0);
      check($sformatf("ws%0d_htrans", i), {30'b0, HTRANS}, 32'h2);
      check($sformatf("ws%0d_haddr", i), HADDR, 32'h200);
      tick();
    end
    HREADY = 1'b1; HRDATA = 32'h1234_5678;
    @(negedge HCLK);
    check("ws_rvalid", {31'b0, data_rvalid_o}, 32'h1);
    check("ws_rdata", data_rdata_o, 32'h1234_5678);
    check("ws_igant_same", {31'b0, instr_gnt_o}, 32'h1);
    tick(); instr_req_i = 1'b0;
    @(negedge HCLK);
    check("ws_irvalid", {31'b0, instr_rvalid_o}, 32'h1);

    // Two-cycle error response on a data read
    tick();
    data_req_i = 1'b1; data_be_i = 4'b1111; data_addr_i = 32'h3000_0010;
    @(negedge HCLK);
    check("er_dgnt", {31'b0, data_gnt_o}, 32'h1);
    tick(); data_req_i = 1'b0;
    instr_req_i = 1'b1; HREADY = 1'b0; HRESP = 1'b1;
    @(negedge HCLK);
    check("er1_htrans", {30'b0, HTRANS}, 32'h0);
    check("er1_no_gnt", {31'b0, instr_gnt_o}, 32'h0);
    check("er1_no_rvalid", {31'b0, data_rvalid_o}, 32'h0);
    tick(); instr_req_i = 1'b0; HREADY = 1'b1;
    @(negedge HCLK);
    check("er2_rvalid", {31'b0, data_rvalid_o}, 32'h1);
    check("er2_err", {31'b0, data_err_o}, 32'h1);
    tick(); HRESP = 1'b0;
    @(negedge HCLK);
    check("er3_rvalid", {31'b0, data_rvalid_o}, 32'h0);

    // Illegal byte enables: local grant, next-cycle error
    tick();
    data_req_i = 1'b1; data_be_i = 4'b0110; data_addr_i = 32'h3000_0020;
    HRDATA = 32'hFFFF_FFFF;
    @(negedge HCLK);
    check("il_dgnt", {31'b0, data_gnt_o}, 32'h1);
    check("il_htrans", {30'b0, HTRANS}, 32'h0);
    tick(); idle_inputs(); instr_req_i = 1'b1;
    @(negedge HCLK);
    check("il_rvalid", {31'b0, data_rvalid_o}, 32'h1);
    check("il_err", {31'b0, data_err_o}, 32'h1);
    check("il_rdata", data_rdata_o, 32'h0);
    check("il_block_gnt", {31'b0, instr_gnt_o}, 32'h0);
    tick(); instr_req_i = 1'b0;

    // Reset in the middle of a stalled data phase
    tick();
    data_req_i = 1'b1; data_be_i = 4'b1111; data_addr_i = 32'h3000_0030;
    @(negedge HCLK);
    check("rm_dgnt", {31'b0, data_gnt_o}, 32'h1);
    tick(); idle_inputs(); HREADY = 1'b0;
    #1 HRESETn = 1'b0;
    #1 HREADY = 1'b1;
    #1 check("rm_no_rvalid", {31'b0, data_rvalid_o}, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();
    @(negedge HCLK);
    check("rm_no_rvalid_after", {31'b0, data_rvalid_o}, 32'h0);

    // Round-robin: one data grant moves priority to instr, then contention
    tick(); data_req_i = 1'b1; data_be_i = 4'b1111; data_addr_i = 32'h7000_0000;
    @(negedge HCLK);
    check("rr_seed_dgnt", {31'b0, r_data_gnt}, 32'h1);
    tick(); instr_req_i = 1'b1; instr_addr_i = 32'h300;
    rr_exp_i = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      check($sformatf("rr%0d_gnt", i), {30'b0, r_instr_gnt, r_data_gnt},
            {30'b0, rr_exp_i[i], ~rr_exp_i[i]});
      check($sformatf("fx%0d_gnt", i), {30'b0, instr_gnt_o, data_gnt_o}, 32'h1);
      tick();
    end
    idle_inputs();

`ifdef IBEX_AHB_SYSTICK_EN
    // SysTick with divide 4: pulse every 5 cycles
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge HCLK);
      if (irq_timer_o) found = 1'b1;
    end
    check("st_found", {31'b0, found}, 32'h1);
    for (int k = 1; k <= 15; k++) begin
      @(negedge HCLK);
      check($sformatf("st_k%0d", k), {31'b0, irq_timer_o}, {31'b0, (k % 5) == 0});
    end
`else
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge HCLK);
      found = found | irq_timer_o;
    end
    check("st_off", {31'b0, found}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibex_ahb_bridge.md
Name: ibex_ahb_bridge

Overview:
Parametrised AHB-Lite master bridge for the Ibex core, replacing the unpipelined instruction/data FSM adapter. It arbitrates the Ibex instruction and data req/gnt/rvalid ports onto one AHB-Lite master port. AHB address and data phases overlap, so a new transfer can be issued in the same cycle the previous one completes. It adds HRESP error return, HPROT, selectable arbitration, and local rejection of byte-enable patterns that AHB cannot express. An optional SysTick generator is included.

Parameters:
ARB_RR, 0, arbitration mode: 0 = fixed data-over-instruction priority; 1 = round-robin.
SYSTICK_W, 24, width of the SysTick divider counter and the divide input.

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous active-low reset
instr_req_i  in  1  Ibex instruction request
instr_addr_i  in  32  instruction address (word-aligned)
instr_gnt_o  out  1  instruction grant
instr_rvalid_o  out  1  instruction response valid
instr_rdata_o  out  32  instruction read data
instr_err_o  out  1  instruction bus error
data_req_i  in  1  data request
data_we_i  in  1  data write enable
data_be_i  in  4  data byte enables
data_addr_i  in  32  data address
data_wdata_i  in  32  data write data
data_gnt_o  out  1  data grant
data_rvalid_o  out  1  data response valid
data_rdata_o  out  32  data read data
data_err_o  out  1  data error
HADDR  out  32  AHB address
HTRANS  out  2  IDLE (00) or NONSEQ (10) only
HSIZE  out  3  transfer size
HWRITE  out  1  write control
HPROT  out  4  protection: bit0 = 0 opcode / 1 data; bit1 = 1 (privileged); bits 3:2 = 00
HWDATA  out  32  write data, driven in the data phase
HRDATA  in  32  read data
HREADY  in  1  transfer ready
HRESP  in  1  error response
SYSTICKCLKDIV  in  SYSTICK_W  SysTick divide value (feature only)
irq_timer_o  out  1  SysTick pulse (feature only)

Behaviour:
- Reset: all outputs 0, HTRANS = IDLE, no data phase pending, round-robin pointer set to data, irq_timer_o = 1.
- Address phase: HTRANS = NONSEQ whenever the arbitrated winner has req high and no error first-cycle is in progress. The transfer is accepted on a cycle with HREADY = 1; the winner's gnt is pulsed combinationally in that same cycle.
- Arbitration hold: if NONSEQ is driven with HREADY = 0, the owner is latched. The owner and HADDR/HSIZE/HWRITE/HPROT stay unchanged until acceptance.
- Round-robin mode: after each grant, priority passes to the other port.
- Data phase: registered owner, we and wdata, 1 cycle after acceptance. HWDATA comes from this register.
  - On the cycle with HREADY = 1, the owner's rvalid pulses for 1 cycle, rdata = HRDATA, err = HRESP.
  - A new address phase may be accepted in that same cycle.
  - Minimum latency: gnt at cycle N, rvalid at N+1.
- Error response:
  - While HRESP = 1 and HREADY = 0, HTRANS is forced to IDLE and no gnt is issued.
  - The error is reported on the following HREADY = 1 cycle.
- Size and address mapping from data_be_i:
  - 0001/0010/0100/1000 → byte at offset 0/1/2/3.
  - 0011/1100 → halfword at offset 0/2.
  - 1111 → word at offset 0.
  - HADDR = {addr[31:2], offset}.
  - Instruction fetches are always word, HSIZE = 010.
- Illegal byte enables (any other pattern, including 0000):
  - gnt is given with no AHB transfer; HTRANS = IDLE that cycle.
  - The next cycle pulses data_rvalid_o with data_err_o = 1 and rdata = 0.
- Outstanding transfers: at most one data phase. The bridge does not grant while a local-error response is pending.
- Reset mid-transfer: the pending phase is dropped immediately and no rvalid is generated.

Optional Feature:
Macro IBEX_AHB_SYSTICK_EN.
- Defined:
  - A SYSTICK_W-bit counter increments each cycle and clears when it equals SYSTICKCLKDIV.
  - irq_timer_o is a registered 1-cycle pulse in the cycle after each match.
  - Divide value D gives a period of D+1 cycles.
  - SYSTICKCLKDIV = 0 holds irq_timer_o at 1.
- Undefined: the SYSTICKCLKDIV port is ignored, irq_timer_o is tied to 0, and the counter logic is absent.

Decomposition:
Package ibex_ahb_pkg holds:
- HTRANS_IDLE and HTRANS_NONSEQ
- HSIZE_BYTE, HSIZE_HALF and HSIZE_WORD
- HPROT constants
- the owner enum (OWN_INSTR, OWN_DATA)

A sub-module, ibex_ahb_be_decode, is natural: combinational be → {hsize, offset, illegal}.

Test Plan:
- Instruction fetch at 0x0000_0100 with HREADY = 1 throughout → gnt at N, HADDR 0x100, HSIZE 010, HPROT[0] = 0, instr_rvalid_o at N+1 with HRDATA.
- Instruction and data requests in the same cycle, ARB_RR = 0 → data granted first. With ARB_RR = 1 and repeated contention, grants alternate I, D, I, D.
- Data byte write, be = 0100, addr 0x2000_0008, wdata 0x00AB_0000 → HADDR 0x2000_000A, HSIZE 000, HWRITE = 1, HWDATA 0x00AB_0000 in the data phase.
- Slave inserts 3 wait states (HREADY = 0) in the data phase, with a second request pending → no gnt and unchanged address during the stall; rvalid and the new gnt occur in the same cycle.
- Two-cycle HRESP error on a data read → HTRANS IDLE in the first error cycle; data_rvalid_o = 1 and data_err_o = 1 on the second.
- be = 0110 → gnt, no NONSEQ, next-cycle data_err_o = 1. With the feature enabled and SYSTICKCLKDIV = 4 → irq_timer_o pulses every 5 cycles.
